// File: rtl/player_input.sv
`timescale 1ns/1ps
// Keyboard front end for Crossy Robbers: turns the HID keycode word into one-cycle
// command pulses with edge detection, hold-to-repeat and opposite-direction cancellation.
module player_input #(
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        tick,
   input  logic        enable,
   input  logic [31:0] keycode,
   output logic [3:0]  p1_move,
   output logic [3:0]  p2_move,
   output logic        start,
   output logic        quit
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam logic [7:0] DELAY_LAST  = 8'(REPEAT_DELAY - 1);
   localparam logic [7:0] PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

   // Held-vector layout: [3:0] p1 {up,down,left,right}, [7:4] p2 same order, [8] Enter, [9] Escape.
   function automatic logic [9:0] decode_keys(input logic [31:0] kc);
      logic [9:0] h;
      logic [7:0] code;
      h = '0;
      for (int s = 0; s < 4; s++) begin
         code = kc[s*8 +: 8];
         case (code)
            8'h07:   h[0] = 1'b1;
            8'h04:   h[1] = 1'b1;
            8'h16:   h[2] = 1'b1;
            8'h1A:   h[3] = 1'b1;
            8'h4F:   h[4] = 1'b1;
            8'h50:   h[5] = 1'b1;
            8'h51:   h[6] = 1'b1;
            8'h52:   h[7] = 1'b1;
            8'h28:   h[8] = 1'b1;
            8'h29:   h[9] = 1'b1;
            default: ;
         endcase
      end
      return h;
   endfunction

   // A movement key only counts while its opposite in the same axis is not held.
   function automatic logic [7:0] cancel_opposites(input logic [7:0] h);
      return {h[7] & ~h[6], h[6] & ~h[7], h[5] & ~h[4], h[4] & ~h[5],
              h[3] & ~h[2], h[2] & ~h[3], h[1] & ~h[0], h[0] & ~h[1]};
   endfunction

   function automatic logic [3:0] pick_one(input logic [3:0] r);
      if (r[3])      return 4'b1000;
      else if (r[2]) return 4'b0100;
      else if (r[1]) return 4'b0010;
      else if (r[0]) return 4'b0001;
      else           return 4'b0000;
   endfunction

   logic [9:0]      held;
   logic [9:0]      held_d;
   logic [7:0]      lock;
   logic [7:0][1:0] state;
   logic [7:0][1:0] state_nx;
   logic [7:0][7:0] cnt;
   logic [7:0][7:0] cnt_nx;
   logic [7:0]      eff;
   logic [7:0]      eff_d;
   logic [7:0]      req;

   // Previous effective state derives from held_d, so a cancelled key whose partner is
   // released sees a rising edge exactly like a fresh press.
   assign eff   = cancel_opposites(held[7:0]);
   assign eff_d = cancel_opposites(held_d[7:0]);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nx = state;
      cnt_nx   = cnt;
      req      = '0;
      for (int i = 0; i < 8; i++) begin
         if (!enable || !eff[i]) begin
            state_nx[i] = ST_IDLE;
            cnt_nx[i]   = '0;
         end else begin
            case (state[i])
               ST_IDLE: begin
                  // lock blocks keys that were already down while movement was disabled
                  if (!eff_d[i] && !lock[i]) begin
                     req[i]      = 1'b1;
                     state_nx[i] = ST_DELAY;
                     cnt_nx[i]   = '0;
                  end
               end
               ST_DELAY: begin
                  if (tick) begin
                     if (cnt[i] == DELAY_LAST) begin
                        req[i]      = 1'b1;
                        state_nx[i] = ST_REPEAT;
                        cnt_nx[i]   = '0;
                     end else begin
                        cnt_nx[i] = cnt[i] + 8'd1;
                     end
                  end
               end
               ST_REPEAT: begin
                  if (tick) begin
                     if (cnt[i] == PERIOD_LAST) begin
                        req[i]    = 1'b1;
                        cnt_nx[i] = '0;
                     end else begin
                        cnt_nx[i] = cnt[i] + 8'd1;
                     end
                  end
               end
               default: begin
                  state_nx[i] = ST_IDLE;
                  cnt_nx[i]   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clk) begin
      // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
      if (Reset) begin
         // NOTE: the per-key FSM and counter arrays are tiny flops, not RAM, so they are reset with everything else.
         held    <= '0;
         held_d  <= '0;
         lock    <= '0;
         state   <= {8{ST_IDLE}};
         cnt     <= '0;
         p1_move <= '0;
         p2_move <= '0;
         start   <= 1'b0;
         quit    <= 1'b0;
      end else begin
         held    <= decode_keys(keycode);
         held_d  <= held;
         lock    <= (lock | {8{~enable}}) & held[7:0];
         state   <= state_nx;
         cnt     <= cnt_nx;
         p1_move <= pick_one(req[3:0]);
         p2_move <= pick_one(req[7:4]);
         start   <= held[8] & ~held_d[8];
         quit    <= held[9] & ~held_d[9];
      end
   end

endmodule

// File: tb/tb_player_input.sv
`timescale 1ns/1ps
// Self-checking bench for player_input: directed scenarios with hand-derived pulse timing,
// then randomized traffic against a tick-counting reference model.
module tb_player_input;

   localparam int DLY = 3;
   localparam int PER = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        tick;
   logic        enable;
   logic [31:0] keycode;
   logic [3:0]  p1_move;
   logic [3:0]  p2_move;
   logic        start;
   logic        quit;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Clk = ~Clk;

   player_input #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .tick    (tick),
      .enable  (enable),
      .keycode (keycode),
      .p1_move (p1_move),
      .p2_move (p2_move),
      .start   (start),
      .quit    (quit)
   );

   // ---------------- reference model ----------------
   // Bit j of a key vector is the key with code key_codes[j].
   logic [7:0] key_codes [10] = '{8'h07, 8'h04, 8'h16, 8'h1A, 8'h4F, 8'h50, 8'h51, 8'h52, 8'h28, 8'h29};
   logic [7:0] pool [12]      = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h28, 8'h29, 8'h33};

   logic [9:0] m_held   = '0;
   logic [9:0] m_held_d = '0;
   logic [7:0] m_lock   = '0;
   logic [7:0] m_active = '0;
   int         m_n [8];
   logic [3:0] e_p1     = '0;
   logic [3:0] e_p2     = '0;
   logic       e_start  = 1'b0;
   logic       e_quit   = 1'b0;

   function automatic logic [9:0] m_decode(input logic [31:0] kc);
      logic [9:0] h = '0;
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < 10; j++)
            if (kc[s*8 +: 8] == key_codes[j]) h[j] = 1'b1;
      return h;
   endfunction

   function automatic logic [7:0] m_usable(input logic [9:0] h);
      logic [7:0] e = '0;
      for (int g = 0; g < 2; g++) begin
         if (!(h[g*4+3] && h[g*4+2])) begin e[g*4+3] = h[g*4+3]; e[g*4+2] = h[g*4+2]; end
         if (!(h[g*4+1] && h[g*4+0])) begin e[g*4+1] = h[g*4+1]; e[g*4+0] = h[g*4+0]; end
      end
      return e;
   endfunction

   function automatic logic [3:0] m_pick(input logic [3:0] r);
      logic [3:0] o = '0;
      for (int b = 0; b < 4; b++)
         if (r[b]) o = 4'b0001 << b;
      return o;
   endfunction

   always @(posedge Clk) begin : model
      logic [7:0] now_ok;
      logic [7:0] was_ok;
      logic [7:0] req;
      int         nn;
      if (Reset) begin
         m_held   <= '0;
         m_held_d <= '0;
         m_lock   <= '0;
         m_active <= '0;
         e_p1     <= '0;
         e_p2     <= '0;
         e_start  <= 1'b0;
         e_quit   <= 1'b0;
      end else begin
         now_ok = m_usable(m_held);
         was_ok = m_usable(m_held_d);
         req    = '0;
         for (int k = 0; k < 8; k++) begin
            if (!enable || !now_ok[k]) begin
               m_active[k] <= 1'b0;
            end else if (!m_active[k]) begin
               if (!was_ok[k] && !m_lock[k]) begin
                  req[k]      = 1'b1;
                  m_active[k] <= 1'b1;
                  m_n[k]      <= 0;
               end
            end else if (tick) begin
               nn = m_n[k] + 1;
               m_n[k] <= nn;
               if (nn == DLY || (nn > DLY && (nn - DLY) % PER == 0)) req[k] = 1'b1;
            end
         end
         e_p1     <= m_pick(req[3:0]);
         e_p2     <= m_pick(req[7:4]);
         e_start  <= m_held[8] & ~m_held_d[8];
         e_quit   <= m_held[9] & ~m_held_d[9];
         m_lock   <= (m_lock | {8{~enable}}) & m_held[7:0];
         m_held_d <= m_held;
         m_held   <= m_decode(keycode);
      end
   end

   // ---------------- scenarios ----------------
   task automatic test_reset();
      Reset = 1'b1; enable = 1'b1; tick = 1'b0; keycode = 32'h0000_1A28;
      repeat (3) @(negedge Clk);
      n_checks++;
      if ({p1_move, p2_move, start, quit} !== 10'b0)
         $display("FAIL reset_outputs: got %b want 0", {p1_move, p2_move, start, quit});
      else n_pass++;
      keycode = '0;
      @(negedge Clk);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      n_checks++;
      if ({p1_move, p2_move, start, quit} !== 10'b0)
         $display("FAIL reset_release_idle: got %b want 0", {p1_move, p2_move, start, quit});
      else n_pass++;
   endtask

   task automatic test_single_press();
      logic [9:0] exp;
      keycode = 32'h0000_001A;
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clk);
         exp = (k == 2) ? {4'b1000, 6'b0} : 10'b0;
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL single_press k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
      end
      keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_repeat();
      logic [9:0] exp;
      for (int k = 0; k <= 45; k++) begin
         if (k > 0) @(negedge Clk);
         exp = (k == 2 || k == 12 || k == 20 || k == 28) ? {4'b0000, 4'b0001, 2'b00} : 10'b0;
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL repeat k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = (k < 30) ? 32'h0000_004F : 32'h0;
         tick    = (k % 4 == 3);
      end
      tick = 1'b0; keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_cancel();
      logic [9:0] exp;
      for (int k = 0; k <= 22; k++) begin
         if (k > 0) @(negedge Clk);
         exp = (k == 12) ? {4'b1000, 6'b0} : 10'b0;
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL cancel k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = (k < 10) ? 32'h0000_161A : (k < 20) ? 32'h0000_001A : 32'h0;
      end
      keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_arbitration();
      logic [9:0] exp;
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) @(negedge Clk);
         exp = (k == 2) ? {4'b1000, 4'b1000, 2'b00} : 10'b0;
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL arbitration k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = (k < 5) ? 32'h0052_041A : 32'h0;
      end
      keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_enable_gate();
      logic [9:0] exp;
      for (int k = 0; k <= 22; k++) begin
         if (k > 0) @(negedge Clk);
         exp = {(k == 19) ? 4'b0001 : 4'b0000, 4'b0000, (k == 2), 1'b0};
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL enable_gate k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = (k < 14) ? 32'h0000_2807 : (k >= 17 && k < 21) ? 32'h0000_0007 : 32'h0;
         enable  = (k >= 6);
      end
      enable = 1'b1; keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_dup_slots();
      logic [9:0] exp;
      for (int k = 0; k <= 7; k++) begin
         if (k > 0) @(negedge Clk);
         exp = {8'b0, (k == 2), 1'b0};
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL dup_slots k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = (k < 4) ? 32'h0028_0028 : 32'h0;
      end
      keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_reset_mid_repeat();
      logic [9:0] exp;
      for (int k = 0; k <= 27; k++) begin
         if (k > 0) @(negedge Clk);
         exp = {(k == 2 || k == 12 || k == 24) ? 4'b0001 : 4'b0000, 6'b0};
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== exp)
            $display("FAIL reset_mid_repeat k=%0d: got %b want %b", k, {p1_move, p2_move, start, quit}, exp);
         else n_pass++;
         keycode = 32'h0000_0007;
         tick    = (k < 19) && (k % 4 == 3);
         Reset   = (k >= 19 && k <= 21);
      end
      Reset = 1'b0; tick = 1'b0; keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_random();
      Reset = 1'b1; enable = 1'b1; tick = 1'b0; keycode = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         n_checks++;
         if ({p1_move, p2_move, start, quit} !== {e_p1, e_p2, e_start, e_quit})
            $display("FAIL random c=%0d: got %b want %b", c,
                     {p1_move, p2_move, start, quit}, {e_p1, e_p2, e_start, e_quit});
         else n_pass++;
         for (int s = 0; s < 4; s++)
            if ($urandom_range(0, 5) == 0) keycode[s*8 +: 8] = pool[$urandom_range(0, 11)];
         tick = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 59) == 0) enable = ~enable;
         Reset = ($urandom_range(0, 249) == 0);
      end
      Reset = 1'b0; enable = 1'b1; tick = 1'b0; keycode = '0;
      repeat (3) @(negedge Clk);
   endtask

   initial begin
      Reset = 1'b1; enable = 1'b1; tick = 1'b0; keycode = '0;
      test_reset();
      test_single_press();
      test_repeat();
      test_cancel();
      test_arbitration();
      test_enable_gate();
      test_dup_slots();
      test_reset_mid_repeat();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
